tcs_scan_ctrl: RTL and testbench
================================

Name: tcs_scan_ctrl

Overview:
- Sequencer for the TCS3200-style colour sensor front end.
- Drives the frequency-scale (s[1:0]), filter-select (s[3:2]) and output-enable pins, and steps the filter through red, green, blue.
- For each filter, waits a settle time, then counts sensor output falling edges over a fixed gate window.
- Presents R/G/B counts plus a one-hot dominant-colour LED code to a consumer through a valid/ready handshake.

Parameters:
- GATE_CYCLES, 50000, clk_50 cycles per measurement window (≥2).
- SETTLE_CYCLES, 500, clk_50 cycles after a filter change before gating starts (≥1).
- CNT_W, 16, width of each channel count.
- SCALE, 2'b11, value driven on s[1:0] while busy (11 = 100% frequency scaling).

Ports:
- clk_50  in  1  system clock, 50 MHz.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  single-cycle request to begin one scan; sampled only in IDLE.
- cont  in  1  continuous mode; level-sensitive.
- sensor_out  in  1  raw sensor frequency output; asynchronous to clk_50.
- s  out  4  [1:0] scaling, [3:2] filter select.
- oe  out  1  sensor output enable, active-low.
- busy  out  1  high from SETTLE entry until DONE exit.
- res_vld  out  1  result valid.
- res_rdy  in  1  consumer ready.
- r_cnt, g_cnt, b_cnt  out  CNT_W each  channel edge counts.
- c_cnt  out  CNT_W  clear-channel count (see Optional Feature).
- led  out  3  dominant colour, one-hot: 100 red, 010 green, 001 blue.

Behaviour:
- Reset (async, rst_n low):
  - state=IDLE; s=4'b0000; oe=1; busy=0; res_vld=0; all counts 0; led=3'b000.
  - Synchronizer flops cleared to 1.
  - Reset asserted mid-scan aborts immediately; no partial result is ever presented.
- Filter codes on s[3:2]: red 00, blue 01, clear 10, green 11.
- Scan order: R, G, B (then C with the feature enabled).
- sensor_out input path:
  - Passes through a 2-flop synchronizer.
  - A falling edge = previous synchronized value 1, current 0; produces a 1-cycle pulse.
- State machine:
  - IDLE:
    - s[1:0]=00 (power-down), oe=1.
    - start=1 in cycle T: at T+1 state=SETTLE, busy=1, oe=0, s[1:0]=SCALE, s[3:2]=red.
  - SETTLE: count exactly SETTLE_CYCLES cycles, then enter GATE; edge counter cleared on entry to GATE.
  - GATE:
    - Exactly GATE_CYCLES cycles; each cycle with an edge pulse increments the edge counter.
    - The counter saturates at 2^CNT_W−1; no wrap.
    - On the last GATE cycle, the final count (including any edge in that cycle) is written to the current channel register.
    - Next state: SETTLE with the next filter code, or DONE after the last channel.
  - DONE:
    - res_vld=1 from the first DONE cycle; led updated in the same cycle.
    - Channel registers and led are frozen while res_vld=1.
    - Transfer occurs in any cycle with res_vld=1 and res_rdy=1.
    - Next cycle after transfer: res_vld=0. If cont=1, go to SETTLE (red), busy stays 1. Otherwise go to IDLE, busy=0, oe=1, s[1:0]=00.
- Results persist on the count and led outputs after the transfer until overwritten by the next scan. Each channel register updates at the end of its own GATE.
- start is ignored outside IDLE. cont is sampled only at the DONE transfer; deasserting cont mid-scan finishes the current scan normally.
- Dominant colour (computed on entry to DONE):
  - led = one-hot of the largest of r_cnt, g_cnt, b_cnt.
  - Ties resolve with priority red > green > blue; all-zero counts give led=100.
  - The clear channel never participates.
- Scan latency from start to res_vld, with N channels: 1 + N·(SETTLE_CYCLES+GATE_CYCLES) cycles.

Optional Feature:
- Macro: TCS_CLEAR_CH_EN.
- Defined:
  - A fourth channel (filter 10, clear) is measured after blue.
  - c_cnt holds its count.
  - N=4.
- Undefined:
  - N=3.
  - c_cnt tied to 0.
  - Filter code 10 is never driven.

Test Plan:
- Reset check: hold rst_n=0 with start=1 -> s=0000, oe=1, busy=0, res_vld=0, led=000. Release reset -> state stays IDLE until start.
- Single scan (GATE_CYCLES=1000, SETTLE_CYCLES=100):
  - Stimulus: sensor period 20 cycles under red, 25 under green, 40 under blue; start pulse at cycle 10; res_rdy=1.
  - Expected: r_cnt=50, g_cnt=40, b_cnt=25, led=100; res_vld rises at cycle 10+1+3·1100; s[3:2] sequence 00,11,01.
- Backpressure: res_rdy=0 for 200 cycles in DONE -> res_vld held, counts and led stable, no new scan. res_rdy=1 -> one transfer, then IDLE with busy=0.
- Saturation and tie: CNT_W=4, period 4 (250 edges) on all filters -> r_cnt=g_cnt=b_cnt=15, led=100 (tie priority).
- Continuous mode: cont=1, start once -> back-to-back scans with SETTLE (red) the cycle after each transfer. Drop cont during scan 2 -> return to IDLE after scan 2 transfer. start pulses while busy are ignored.
- Abort: rst_n low during green GATE -> immediate reset values. A new start -> fresh scan beginning at red, correct counts.

Source files
------------

// File: rtl/tcs_scan_ctrl.sv
// tcs_scan_ctrl: sequencer for a TCS3200-style colour sensor front end.
// Steps the filter through red, green, blue (and clear when TCS_CLEAR_CH_EN
// is defined). For each filter it waits SETTLE_CYCLES, then counts
// synchronized falling edges of sensor_out for GATE_CYCLES. R/G/B(/C) counts
// and a one-hot dominant-colour code are then offered through valid/ready.
//
// Ports:
//   clk_50, rst_n           clock, asynchronous active-low reset
//   start                   single-cycle scan request, honoured only in IDLE
//   cont                    continuous mode, sampled at result transfer
//   sensor_out              raw sensor frequency output (asynchronous)
//   s[3:0]                  [1:0] frequency scaling, [3:2] filter select
//   oe                      sensor output enable, active-low
//   busy                    high from SETTLE entry until DONE exit
//   res_vld / res_rdy       result handshake
//   r_cnt/g_cnt/b_cnt/c_cnt channel edge counts (c_cnt is 0 without clear)
//   led                     dominant colour: 100 red, 010 green, 001 blue
//
// Optional feature macro: TCS_CLEAR_CH_EN (adds the clear channel).

module tcs_scan_ctrl #(
   parameter int unsigned GATE_CYCLES   = 50000,
   parameter int unsigned SETTLE_CYCLES = 500,
   parameter int unsigned CNT_W         = 16,
   parameter logic [1:0]  SCALE         = 2'b11
) (
   input  logic             clk_50,
   input  logic             rst_n,
   input  logic             start,
   input  logic             cont,
   input  logic             sensor_out,
   output logic [3:0]       s,
   output logic             oe,
   output logic             busy,
   output logic             res_vld,
   input  logic             res_rdy,
   output logic [CNT_W-1:0] r_cnt,
   output logic [CNT_W-1:0] g_cnt,
   output logic [CNT_W-1:0] b_cnt,
   output logic [CNT_W-1:0] c_cnt,
   output logic [2:0]       led
);

`ifdef TCS_CLEAR_CH_EN
   localparam int unsigned NCH = 4;
`else
   localparam int unsigned NCH = 3;
`endif
   localparam int unsigned TMR_MAX = (GATE_CYCLES > SETTLE_CYCLES) ? GATE_CYCLES : SETTLE_CYCLES;
   localparam int unsigned TMR_W   = $clog2(TMR_MAX);
   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   typedef enum logic [1:0] {ST_IDLE, ST_SETTLE, ST_GATE, ST_DONE} state_e;

   // Channel index to filter pin code: red 00, green 11, blue 01, clear 10.
   function automatic logic [1:0] filt_code(input logic [1:0] ch);
      case (ch)
         2'd0:    filt_code = 2'b00;
         2'd1:    filt_code = 2'b11;
         2'd2:    filt_code = 2'b01;
         default: filt_code = 2'b10;
      endcase
   endfunction

   state_e           state_q, state_d;
   logic [TMR_W-1:0] tmr_q, tmr_d;
   logic [1:0]       ch_q, ch_d;
   logic [CNT_W-1:0] edge_q, edge_d, edge_inc;
   logic [CNT_W-1:0] r_q, r_d, g_q, g_d, b_q, b_d;
   logic [2:0]       led_q, led_d;
   logic [3:0]       s_q, s_d;
   logic             oe_q, oe_d, busy_q, busy_d, vld_q, vld_d;
   logic [2:0]       sync_q;
   logic             edge_pulse, settle_last, gate_last, last_ch;

   // sync_q[1] is the synchronized level, sync_q[2] its previous value.
   always_ff @(posedge clk_50 or negedge rst_n) begin
      if (!rst_n) sync_q <= 3'b111;
      else        sync_q <= {sync_q[1:0], sensor_out};
   end

   assign edge_pulse  = sync_q[2] & ~sync_q[1];
   assign settle_last = (tmr_q == TMR_W'(SETTLE_CYCLES - 1));
   assign gate_last   = (tmr_q == TMR_W'(GATE_CYCLES - 1));
   assign last_ch     = (ch_q == 2'(NCH - 1));

   // State register.
   always_ff @(posedge clk_50 or negedge rst_n) begin
      if (!rst_n) state_q <= ST_IDLE;
      else        state_q <= state_d;
   end

   // Next-state logic.
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE:   if (start) state_d = ST_SETTLE;
         ST_SETTLE: if (settle_last) state_d = ST_GATE;
         ST_GATE:   if (gate_last) state_d = last_ch ? ST_DONE : ST_SETTLE;
         ST_DONE:   if (vld_q && res_rdy) state_d = cont ? ST_SETTLE : ST_IDLE;
         default:   state_d = ST_IDLE;
      endcase
   end

   // Timer, edge counter, channel registers and dominant colour.
   always_comb begin
      tmr_d    = '0;
      edge_d   = '0;
      ch_d     = ch_q;
      r_d      = r_q;
      g_d      = g_q;
      b_d      = b_q;
      led_d    = led_q;
      edge_inc = (edge_pulse && (edge_q != CNT_MAX)) ? edge_q + CNT_W'(1) : edge_q;
      if ((state_q == ST_SETTLE || state_q == ST_GATE) && state_d == state_q)
         tmr_d = tmr_q + TMR_W'(1);
      // Counter is zero throughout SETTLE, so GATE always starts from 0.
      if (state_q == ST_GATE)
         edge_d = edge_inc;
      if (state_q == ST_GATE && gate_last) begin
         case (ch_q)
            2'd0:    r_d = edge_inc;
            2'd1:    g_d = edge_inc;
            2'd2:    b_d = edge_inc;
            default: ;
         endcase
      end
      if (state_d == ST_SETTLE && state_q != ST_SETTLE)
         ch_d = (state_q == ST_GATE) ? ch_q + 2'd1 : 2'd0;
      // Ties favour red, then green; clear never participates.
      if (state_d == ST_DONE && state_q == ST_GATE) begin
         if (r_d >= g_d && r_d >= b_d) led_d = 3'b100;
         else if (g_d >= b_d)          led_d = 3'b010;
         else                          led_d = 3'b001;
      end
   end

   // Output decode from the next state, so pins change with the state.
   always_comb begin
      busy_d = 1'b0;
      oe_d   = 1'b1;
      vld_d  = 1'b0;
      s_d    = 4'b0000;
      if (state_d != ST_IDLE) begin
         busy_d = 1'b1;
         oe_d   = 1'b0;
         s_d    = {filt_code(ch_d), SCALE};
      end
      if (state_d == ST_DONE) vld_d = 1'b1;
   end

   always_ff @(posedge clk_50 or negedge rst_n) begin
      if (!rst_n) begin
         tmr_q  <= '0;
         ch_q   <= '0;
         edge_q <= '0;
         r_q    <= '0;
         g_q    <= '0;
         b_q    <= '0;
         led_q  <= 3'b000;
         s_q    <= 4'b0000;
         oe_q   <= 1'b1;
         busy_q <= 1'b0;
         vld_q  <= 1'b0;
      end else begin
         tmr_q  <= tmr_d;
         ch_q   <= ch_d;
         edge_q <= edge_d;
         r_q    <= r_d;
         g_q    <= g_d;
         b_q    <= b_d;
         led_q  <= led_d;
         s_q    <= s_d;
         oe_q   <= oe_d;
         busy_q <= busy_d;
         vld_q  <= vld_d;
      end
   end

`ifdef TCS_CLEAR_CH_EN
   logic [CNT_W-1:0] c_q;

   always_ff @(posedge clk_50 or negedge rst_n) begin
      if (!rst_n)
         c_q <= '0;
      else if (state_q == ST_GATE && gate_last && ch_q == 2'd3)
         c_q <= edge_inc;
   end

   assign c_cnt = c_q;
`else
   assign c_cnt = '0;
`endif

   assign s       = s_q;
   assign oe      = oe_q;
   assign busy    = busy_q;
   assign res_vld = vld_q;
   assign r_cnt   = r_q;
   assign g_cnt   = g_q;
   assign b_cnt   = b_q;
   assign led     = led_q;

endmodule

// File: tb/tb_tcs_scan_ctrl.sv
// Bench for tcs_scan_ctrl: two instances (16-bit and 4-bit counts) run in
// lockstep on a shared sensor model whose period depends on the filter pins.
module tb_tcs_scan_ctrl;

   localparam int unsigned G  = 1000;
   localparam int unsigned S  = 100;
`ifdef TCS_CLEAR_CH_EN
   localparam int unsigned NCH = 4;
   localparam logic [7:0]  EXP_SEQ = 8'b00_11_01_10;
`else
   localparam int unsigned NCH = 3;
   localparam logic [7:0]  EXP_SEQ = 8'b00_00_11_01;
`endif
   localparam int unsigned SCAN_LAT = 1 + NCH * (S + G);

   typedef struct {
      int unsigned pr, pg, pb, pc;
      int unsigned er, eg, eb, ec;
      logic [2:0]  eled, eled_s;
      int unsigned hold;
      bit          early;
   } vec_t;

   logic clk_50 = 1'b0, rst_n = 1'b0, start = 1'b0, cont = 1'b0, res_rdy = 1'b0;
   logic sens = 1'b1;
   logic [3:0]  s_a, s_b;
   logic        oe_a, oe_b, busy_a, busy_b, vld_a, vld_b;
   logic [15:0] r_a, g_a, b_a, c_a;
   logic [3:0]  r_b, g_b, b_b, c_b;
   logic [2:0]  led_a, led_b;

   int errors = 0;
   int checks = 0;
   int unsigned per [4];
   int unsigned gen_k = 0, gen_lp = 0;
   logic [1:0]  gen_lf = 2'b00;
   vec_t tbl [7];
   int unsigned divs [15] = '{0, 4, 5, 8, 10, 20, 25, 40, 50, 100, 125, 200, 250, 500, 1000};

   tcs_scan_ctrl #(.GATE_CYCLES(G), .SETTLE_CYCLES(S), .CNT_W(16)) dut_a (
      .clk_50(clk_50), .rst_n(rst_n), .start(start), .cont(cont), .sensor_out(sens),
      .s(s_a), .oe(oe_a), .busy(busy_a), .res_vld(vld_a), .res_rdy(res_rdy),
      .r_cnt(r_a), .g_cnt(g_a), .b_cnt(b_a), .c_cnt(c_a), .led(led_a));

   tcs_scan_ctrl #(.GATE_CYCLES(G), .SETTLE_CYCLES(S), .CNT_W(4)) dut_b (
      .clk_50(clk_50), .rst_n(rst_n), .start(start), .cont(cont), .sensor_out(sens),
      .s(s_b), .oe(oe_b), .busy(busy_b), .res_vld(vld_b), .res_rdy(res_rdy),
      .r_cnt(r_b), .g_cnt(g_b), .b_cnt(b_b), .c_cnt(c_b), .led(led_b));

   always #5 clk_50 = ~clk_50;

   // Sensor model: square wave of per[filter] cycles, phase restarted whenever
   // the filter or period changes; period 0 means a constant high output.
   always @(negedge clk_50) begin
      int unsigned p;
      p = per[s_a[3:2]];
      if (s_a[3:2] != gen_lf || p != gen_lp) gen_k = 0;
      else if (p != 0) gen_k = (gen_k + 1 == p) ? 0 : gen_k + 1;
      gen_lf = s_a[3:2];
      gen_lp = p;
      sens   = (p == 0) ? 1'b1 : (gen_k < p / 2);
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   // Reference model: edges in a window of G cycles, saturated at maxv.
   function automatic int unsigned cnt_of(input int unsigned p, input int unsigned maxv);
      int unsigned n;
      n = (p == 0) ? 0 : G / p;
      return (n > maxv) ? maxv : n;
   endfunction

   function automatic int unsigned sat15(input int unsigned x);
      return (x > 15) ? 15 : x;
   endfunction

   function automatic logic [2:0] dom(input int unsigned r, input int unsigned g, input int unsigned b);
      if (r >= g && r >= b) return 3'b100;
      if (g >= b)           return 3'b010;
      return 3'b001;
   endfunction

   function automatic vec_t mk(input int unsigned pr, pg, pb, pc, er, eg, eb, ec,
                               input logic [2:0] eled, eled_s, input int unsigned hold, input bit early);
      vec_t v;
      v.pr = pr; v.pg = pg; v.pb = pb; v.pc = pc;
      v.er = er; v.eg = eg; v.eb = eb; v.ec = ec;
      v.eled = eled; v.eled_s = eled_s; v.hold = hold; v.early = early;
      return v;
   endfunction

   task automatic set_per(input vec_t v);
      per[0] = v.pr; per[3] = v.pg; per[1] = v.pb; per[2] = v.pc;
   endtask

   // One full scan from start (or from the re-entry after a cont transfer).
   task automatic do_scan(input vec_t v, input bit do_start, input bit poke, input bit cont_after);
      int unsigned k, bad, nseq;
      logic [7:0]  seq;
      logic [1:0]  lastf;
      bit          got, stable;
      set_per(v);
      res_rdy = v.early;
      if (do_start) begin
         @(negedge clk_50); start = 1'b1;
         @(negedge clk_50); start = 1'b0;
      end
      k = 1; bad = 0; nseq = 1; got = 0;
      lastf = s_a[3:2];
      seq = {6'b0, lastf};
      while (!got && k <= SCAN_LAT + 20) begin
         if (vld_a === 1'b1) got = 1;
         else begin
            if (busy_a !== 1'b1 || s_a[1:0] !== 2'b11 || oe_a !== 1'b0) bad++;
            if (s_a[3:2] !== lastf) begin
               lastf = s_a[3:2];
               seq = {seq[5:0], lastf};
               nseq++;
            end
            if (poke && k == 500) begin start = 1'b1; cont = 1'b0; end
            else start = 1'b0;
            @(negedge clk_50);
            k++;
         end
      end
      chk("latency", 64'(got ? k : 0), 64'(SCAN_LAT));
      chk("filter_seq", 64'(seq), 64'(EXP_SEQ));
      chk("filter_steps", 64'(nseq), 64'(NCH));
      chk("busy_pins", 64'(bad), 64'd0);
      chk("vld_sat", 64'(vld_b), 64'd1);
      chk("r_cnt", 64'(r_a), 64'(v.er));
      chk("g_cnt", 64'(g_a), 64'(v.eg));
      chk("b_cnt", 64'(b_a), 64'(v.eb));
      chk("c_cnt", 64'(c_a), 64'(NCH == 4 ? v.ec : 0));
      chk("led", 64'(led_a), 64'(v.eled));
      chk("r_sat", 64'(r_b), 64'(sat15(v.er)));
      chk("g_sat", 64'(g_b), 64'(sat15(v.eg)));
      chk("b_sat", 64'(b_b), 64'(sat15(v.eb)));
      chk("c_sat", 64'(c_b), 64'(NCH == 4 ? sat15(v.ec) : 0));
      chk("led_sat", 64'(led_b), 64'(v.eled_s));
      if (v.early) begin
         @(negedge clk_50);
         chk("vld_one_cycle", 64'(vld_a), 64'd0);
      end else begin
         stable = 1;
         repeat (v.hold) begin
            @(negedge clk_50);
            if (vld_a !== 1'b1 || busy_a !== 1'b1 || r_a !== 16'(v.er) || g_a !== 16'(v.eg) ||
                b_a !== 16'(v.eb) || led_a !== v.eled) stable = 0;
         end
         chk("hold_stable", 64'(stable), 64'd1);
         res_rdy = 1'b1;
         @(negedge clk_50);
         chk("vld_drop", 64'(vld_a), 64'd0);
      end
      res_rdy = 1'b0;
      chk("busy_after", 64'(busy_a), 64'(cont_after));
      if (!cont_after) chk("idle_pins", 64'({s_a, oe_a}), 64'(5'b00001));
      else             chk("resettle_red", 64'({s_a, oe_a}), 64'(5'b00110));
      chk("persist_r", 64'(r_a), 64'(v.er));
      chk("persist_led", 64'(led_a), 64'(v.eled));
   endtask

   initial begin
      int unsigned busy_seen;
      vec_t rv;
      per = '{0, 0, 0, 0};
      tbl[0] = mk(20, 25, 40, 50,   50, 40, 25, 20,     3'b100, 3'b100, 0, 1);
      tbl[1] = mk(40, 20, 25, 100,  25, 50, 40, 10,     3'b010, 3'b100, 200, 0);
      tbl[2] = mk(50, 100, 8, 0,    20, 10, 125, 0,     3'b001, 3'b100, 3, 0);
      tbl[3] = mk(0, 0, 0, 0,       0, 0, 0, 0,         3'b100, 3'b100, 0, 0);
      tbl[4] = mk(4, 4, 4, 4,       250, 250, 250, 250, 3'b100, 3'b100, 1, 0);
      tbl[5] = mk(125, 125, 200, 1000, 8, 8, 5, 1,      3'b100, 3'b100, 5, 0);
      tbl[6] = mk(200, 125, 125, 5, 5, 8, 8, 200,       3'b010, 3'b010, 2, 0);

      // Reset with start held high.
      start = 1'b1;
      repeat (3) @(negedge clk_50);
      chk("rst_pins", 64'({s_a, oe_a, busy_a, vld_a}), 64'(7'b0000_1_0_0));
      chk("rst_led", 64'(led_a), 64'd0);
      chk("rst_cnt", 64'({r_a, g_a, b_a, c_a}), 64'd0);
      rst_n = 1'b1;
      start = 1'b0;
      busy_seen = 0;
      repeat (20) begin
         @(negedge clk_50);
         if (busy_a !== 1'b0 || s_a !== 4'b0000) busy_seen++;
      end
      chk("idle_after_rst", 64'(busy_seen), 64'd0);

      for (int i = 0; i < 7; i++) do_scan(tbl[i], 1, 0, 0);

      // Continuous mode: second scan restarts without start; cont dropped and
      // start poked mid-scan.
      cont = 1'b1;
      do_scan(tbl[1], 1, 0, 1);
      do_scan(tbl[2], 0, 1, 0);
      busy_seen = 0;
      repeat (50) begin
         @(negedge clk_50);
         if (busy_a !== 1'b0) busy_seen++;
      end
      chk("no_rescan", 64'(busy_seen), 64'd0);

      // Abort during green GATE.
      set_per(tbl[1]);
      @(negedge clk_50); start = 1'b1;
      @(negedge clk_50); start = 1'b0;
      repeat (S + G + S + 99) @(negedge clk_50);
      chk("abort_green", 64'({s_a[3:2], busy_a}), 64'(3'b11_1));
      rst_n = 1'b0;
      #1;
      chk("abort_pins", 64'({s_a, oe_a, busy_a, vld_a}), 64'(7'b0000_1_0_0));
      chk("abort_cnt", 64'({r_a, g_a, b_a, led_a}), 64'd0);
      @(negedge clk_50);
      rst_n = 1'b1;
      do_scan(tbl[5], 1, 0, 0);

      // Randomized scans against the reference model.
      for (int i = 0; i < 5; i++) begin
         rv.pr = divs[$urandom_range(0, 14)];
         rv.pg = divs[$urandom_range(0, 14)];
         rv.pb = divs[$urandom_range(0, 14)];
         rv.pc = divs[$urandom_range(0, 14)];
         rv.er = cnt_of(rv.pr, 65535);
         rv.eg = cnt_of(rv.pg, 65535);
         rv.eb = cnt_of(rv.pb, 65535);
         rv.ec = cnt_of(rv.pc, 65535);
         rv.eled   = dom(rv.er, rv.eg, rv.eb);
         rv.eled_s = dom(sat15(rv.er), sat15(rv.eg), sat15(rv.eb));
         rv.hold   = $urandom_range(0, 20);
         rv.early  = 0;
         do_scan(rv, 1, 0, 0);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
